// File: rtl/dm_4k_if.sv
// Bus between the MEM stage and the 4 KiB data memory.
// The master drives the address, byte mask and write data; the memory returns the read word.
interface dm_4k_if;
  logic [11:2] addr;
  logic [3:0]  be;
  logic [31:0] din;
  logic        we;
  logic [31:0] dout;

  modport master (output addr, be, din, we, input dout);
  modport slave  (input addr, be, din, we, output dout);
endinterface

// File: rtl/dm_4k.sv
// 4 KiB MIPS data memory: 1024 x 32-bit words, byte-masked synchronous writes,
// combinational reads, whole-array asynchronous clear.
module dm_4k (
  input  logic     clk,
  input  logic     rst_n,
  dm_4k_if.slave   bus
);
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int DW    = 32;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] word_addr;

  assign word_addr = bus.addr;

  // Lanes with a clear enable keep their old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.we) begin
      for (int b = 0; b < DW / 8; b++) begin
        if (bus.be[b]) begin
          mem[word_addr][8*b +: 8] <= bus.din[8*b +: 8];
        end
      end
    end
  end

  assign bus.dout = mem[word_addr];
endmodule

// File: tb/tb_dm_4k.sv
// Self-checking bench for dm_4k: reset sweep, table of write/read vectors scored
// through a queue, plus read-during-write and mid-run asynchronous reset sequences.
module tb_dm_4k;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  dm_4k_if bus ();

  dm_4k dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [9:0]  addr;
    logic [3:0]  be;
    logic [31:0] din;
    logic        we;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  vec_t vecs[12];
  sb_t  sb_q[$];
  int   applied = 0;
  int   miscompares = 0;

  task automatic compareVal(input string name, input logic [31:0] actual, input logic [31:0] exp);
    applied++;
    if (actual !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: dout=%h expected=%h", name, actual, exp);
    end
  endtask

  // Drive one vector on the falling edge and record what dout must read after the next rising edge.
  task automatic applyStimulus(input vec_t v);
    sb_t e;
    @(negedge clk);
    bus.addr = v.addr;
    bus.be   = v.be;
    bus.din  = v.din;
    bus.we   = v.we;
    e.name = v.name;
    e.exp  = v.exp;
    sb_q.push_back(e);
  endtask

  task automatic checkOutput();
    sb_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      applied++;
      miscompares++;
      $display("[TB] FAIL scoreboard_empty: dout=%h expected=<entry>", bus.dout);
    end else begin
      e = sb_q.pop_front();
      compareVal(e.name, bus.dout, e.exp);
    end
  endtask

  initial begin
    vecs[0]  = '{"full_word_a2",     10'd2,    4'b1111, 32'hABCC_0010, 1'b1, 32'hABCC_0010};
    vecs[1]  = '{"partial_a2",       10'd2,    4'b0011, 32'h38C6_0FFF, 1'b1, 32'hABCC_0FFF};
    vecs[2]  = '{"lane2_a5",         10'd5,    4'b0100, 32'hFFFF_FFFF, 1'b1, 32'h00FF_0000};
    vecs[3]  = '{"lane3_a5",         10'd5,    4'b1000, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_0000};
    vecs[4]  = '{"full_a1023",       10'd1023, 4'b1111, 32'h1234_5678, 1'b1, 32'h1234_5678};
    vecs[5]  = '{"isolate_a0",       10'd0,    4'b1111, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000};
    vecs[6]  = '{"isolate_a1022",    10'd1022, 4'b1111, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000};
    vecs[7]  = '{"we0_a1023",        10'd1023, 4'b1111, 32'h0000_0000, 1'b0, 32'h1234_5678};
    vecs[8]  = '{"be0_noop_a1023",   10'd1023, 4'b0000, 32'hFFFF_FFFF, 1'b1, 32'h1234_5678};
    vecs[9]  = '{"lane0_a5",         10'd5,    4'b0001, 32'h0000_00AA, 1'b1, 32'hFFFF_00AA};
    vecs[10] = '{"lane1_a5",         10'd5,    4'b0010, 32'h0000_BB00, 1'b1, 32'hFFFF_BBAA};
    vecs[11] = '{"reread_a2",        10'd2,    4'b1111, 32'h0000_0000, 1'b0, 32'hABCC_0FFF};

    // Reset held with writes requested: the array must stay clear.
    bus.addr = 10'd2;
    bus.be   = 4'hF;
    bus.din  = 32'hFFFF_FFFF;
    bus.we   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.addr = 10'd0;
    #1 compareVal("reset_a0", bus.dout, 32'h0);
    bus.addr = 10'd2;
    #1 compareVal("reset_a2", bus.dout, 32'h0);
    bus.addr = 10'd1023;
    #1 compareVal("reset_a1023", bus.dout, 32'h0);

    // Release between edges; the very next rising edge carries the first table write.
    @(posedge clk);
    #2;
    bus.we = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      checkOutput();
    end
    if (sb_q.size() != 0) begin
      applied++;
      miscompares++;
      $display("[TB] FAIL scoreboard_leftover: entries=%0d expected=0", sb_q.size());
    end

    // Read-during-write: old word before the edge, merged word after, no din forwarding.
    @(negedge clk);
    bus.addr = 10'd5;
    bus.be   = 4'b1100;
    bus.din  = 32'h55AA_55AA;
    bus.we   = 1'b1;
    #1 compareVal("rdw_before_a5", bus.dout, 32'hFFFF_BBAA);
    @(posedge clk);
    #1 compareVal("rdw_after_a5", bus.dout, 32'h55AA_BBAA);
    @(negedge clk);
    bus.we = 1'b0;

    // Asynchronous reset pulse between edges clears everything without a clock.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.addr = 10'd2;
    #1 compareVal("async_rst_a2", bus.dout, 32'h0);
    bus.addr = 10'd1023;
    #1 compareVal("async_rst_a1023", bus.dout, 32'h0);
    bus.addr = 10'd5;
    #1 compareVal("async_rst_a5", bus.dout, 32'h0);
    rst_n = 1'b1;

    // Post-reset write still works.
    @(negedge clk);
    bus.addr = 10'd2;
    bus.be   = 4'b1001;
    bus.din  = 32'hDEAD_BEEF;
    bus.we   = 1'b1;
    @(posedge clk);
    #1 compareVal("post_rst_write_a2", bus.dout, 32'hDE00_00EF);
    @(negedge clk);
    bus.we = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
